// File: rtl/pwm_nch_dt.sv
// pwm_nch_dt: multi-channel PWM with complementary outputs and dead-time insertion.
// Ports:
//   clk          - clock, all state updates on rising edge
//   rst_n        - asynchronous active-low reset
//   en           - run enable; low holds the counter at 0 and forces outputs off
//   duty         - NCH packed duty fields, channel i at [i*WIDTH +: WIDTH]
//   duty_vld     - strobe capturing all duty fields into the pending register
//   dead_time    - dead-time in cycles, shared by all channels
//   pwm_hi       - per-channel high-side drive
//   pwm_lo       - per-channel low-side drive
//   period_start - high during the cycle in which the counter is 0
module pwm_nch_dt #(
    parameter int WIDTH  = 11,
    parameter int NCH    = 2,
    parameter int DT_W   = 6,
    parameter int CENTER = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [NCH*WIDTH-1:0]  duty,
    input  logic                  duty_vld,
    input  logic [DT_W-1:0]       dead_time,
    output logic [NCH-1:0]        pwm_hi,
    output logic [NCH-1:0]        pwm_lo,
    output logic                  period_start
);
    localparam logic [WIDTH-1:0] MAX    = '1;
    localparam logic [DT_W-1:0]  DT_MAX = '1;

    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic             dir, dir_nxt;
    logic             wrap;
    logic [WIDTH-1:0] pend [NCH];
    logic [WIDTH-1:0] act  [NCH];
    logic [DT_W-1:0]  act_dt;
    logic [DT_W-1:0]  dtc  [NCH];
    logic [NCH-1:0]   raw_q, raw_nxt;

    // wrap marks the edge on which the counter returns to 0 (period boundary)
    always_comb begin
        cnt_nxt = cnt + 1'b1;
        dir_nxt = dir;
        wrap    = (cnt == MAX);
        if (CENTER != 0) begin
            wrap    = dir && (cnt == WIDTH'(1));
            cnt_nxt = (dir || cnt == MAX) ? cnt - 1'b1 : cnt + 1'b1;
            dir_nxt = dir ? (cnt != WIDTH'(1)) : (cnt == MAX);
        end
        if (!en) begin
            cnt_nxt = '0;
            dir_nxt = 1'b0;
            wrap    = 1'b0;
        end
    end

    always_comb begin
        raw_nxt = '0;
        for (int i = 0; i < NCH; i++)
            raw_nxt[i] = en && (cnt < act[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            dir    <= 1'b0;
            act_dt <= '0;
            raw_q  <= '0;
            pwm_hi <= '0;
            pwm_lo <= '0;
            for (int i = 0; i < NCH; i++) begin
                pend[i] <= '0;
                act[i]  <= '0;
                dtc[i]  <= '0;
            end
        end else begin
            cnt   <= cnt_nxt;
            dir   <= dir_nxt;
            raw_q <= raw_nxt;
            if (wrap)
                act_dt <= dead_time;
            for (int i = 0; i < NCH; i++) begin
                if (duty_vld)
                    pend[i] <= duty[i*WIDTH +: WIDTH];
                // a strobe coinciding with the boundary bypasses pending
                if (wrap)
                    act[i] <= duty_vld ? duty[i*WIDTH +: WIDTH] : pend[i];
                // dtc restarts on the same edge raw_q toggles, so it counts cycles of stable raw_q
                dtc[i]    <= (raw_nxt[i] != raw_q[i]) ? '0 : (dtc[i] == DT_MAX ? dtc[i] : dtc[i] + 1'b1);
                pwm_hi[i] <= en && raw_q[i] && (dtc[i] >= act_dt);
                pwm_lo[i] <= en && !raw_q[i] && (dtc[i] >= act_dt);
            end
        end
    end

    assign period_start = rst_n && en && (cnt == '0);
endmodule

// File: tb/tb_pwm_nch_dt.sv
// tb_pwm_nch_dt: checks edge- and center-aligned instances against a period-position model.
module tb_pwm_nch_dt;
    localparam int W  = 4;
    localparam int N  = 2;
    localparam int DW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic           duty_vld = 1'b0;
    logic [N*W-1:0] duty = '0;
    logic [DW-1:0]  dead_time = '0;
    logic [N-1:0]   hi [2];
    logic [N-1:0]   lo [2];
    logic           ps [2];

    pwm_nch_dt #(.WIDTH(W), .NCH(N), .DT_W(DW), .CENTER(0)) u_e (
        .clk(clk), .rst_n(rst_n), .en(en), .duty(duty), .duty_vld(duty_vld),
        .dead_time(dead_time), .pwm_hi(hi[0]), .pwm_lo(lo[0]), .period_start(ps[0])
    );
    pwm_nch_dt #(.WIDTH(W), .NCH(N), .DT_W(DW), .CENTER(1)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en), .duty(duty), .duty_vld(duty_vld),
        .dead_time(dead_time), .pwm_hi(hi[1]), .pwm_lo(lo[1]), .period_start(ps[1])
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Model: position within the period, counter value derived from it arithmetically;
    // outputs follow from a raw_q history window of dead_time+1 cycles.
    int pos [2];
    int act [2][N];
    int pend [N];
    int dt [2];
    int hist [2][N][16];
    bit mhi [2][N];
    bit mlo [2][N];
    int m_c;
    bit m_r, ok_hi, ok_lo;

    function automatic int len(int k);
        return k != 0 ? 30 : 16;
    endfunction

    function automatic int cnt_of(int k, int p);
        return (k != 0 && p > 15) ? 30 - p : p;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                pos[k] = 0;
                dt[k] = 0;
                for (int i = 0; i < N; i++) begin
                    act[k][i] = 0;
                    mhi[k][i] = 0;
                    mlo[k][i] = 0;
                    hist[k][i][0] = 0;
                    for (int j = 1; j < 16; j++) hist[k][i][j] = 2;
                end
            end
            for (int i = 0; i < N; i++) pend[i] = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_c = cnt_of(k, pos[k]);
                for (int i = 0; i < N; i++) begin
                    ok_hi = 1;
                    ok_lo = 1;
                    for (int j = 0; j <= dt[k]; j++) begin
                        if (hist[k][i][j] != 1) ok_hi = 0;
                        if (hist[k][i][j] != 0) ok_lo = 0;
                    end
                    mhi[k][i] = en && ok_hi;
                    mlo[k][i] = en && ok_lo;
                    m_r = en && (m_c < act[k][i]);
                    for (int j = 15; j > 0; j--) hist[k][i][j] = hist[k][i][j-1];
                    hist[k][i][0] = int'(m_r);
                end
                if (en && pos[k] == len(k) - 1) begin
                    for (int i = 0; i < N; i++) act[k][i] = duty_vld ? int'(duty[i*W +: W]) : pend[i];
                    dt[k] = int'(dead_time);
                end
                pos[k] = en ? (pos[k] + 1) % len(k) : 0;
            end
            if (duty_vld)
                for (int i = 0; i < N; i++) pend[i] = int'(duty[i*W +: W]);
        end
    end

    always begin
        logic [N-1:0] eh, el;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < N; i++) begin
                eh[i] = mhi[k][i];
                el[i] = mlo[k][i];
            end
            chk($sformatf("model_hi%0d", k), 32'(hi[k]), 32'(eh));
            chk($sformatf("model_lo%0d", k), 32'(lo[k]), 32'(el));
            chk($sformatf("model_ps%0d", k), 32'(ps[k]), 32'(rst_n && en && cnt_of(k, pos[k]) == 0));
            chk($sformatf("overlap%0d", k), 32'(hi[k] & lo[k]), 32'd0);
        end
    end

    int nh [2][N];
    int nl [2][N];
    int np [2];

    task automatic count(int n);
        for (int k = 0; k < 2; k++) begin
            np[k] = 0;
            for (int i = 0; i < N; i++) begin
                nh[k][i] = 0;
                nl[k][i] = 0;
            end
        end
        repeat (n) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) begin
                np[k] += int'(ps[k]);
                for (int i = 0; i < N; i++) begin
                    nh[k][i] += int'(hi[k][i]);
                    nl[k][i] += int'(lo[k][i]);
                end
            end
        end
    endtask

    task automatic set(int d0, int d1, int dtv);
        @(negedge clk);
        duty = {W'(d1), W'(d0)};
        dead_time = DW'(dtv);
        duty_vld = 1'b1;
        @(negedge clk);
        duty_vld = 1'b0;
    endtask

    task automatic wait_cnt(int c);
        int t = 0;
        @(negedge clk);
        while (cnt_of(0, pos[0]) != c && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            checks++;
            errs++;
            $display("FAIL wait_cnt: timed out waiting for cnt %0d", c);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ps_e", 32'(ps[0]), 0);
        chk("rst_ps_c", 32'(ps[1]), 0);
        chk("rst_lo_e", 32'(lo[0]), 0);
        rst_n = 1'b1;
        #1;
        chk("first_ps_e", 32'(ps[0]), 1);
        chk("first_ps_c", 32'(ps[1]), 1);
        @(posedge clk);
        #1;
        chk("first_lo_e", 32'(lo[0]), 3);

        set(5, 15, 0);
        repeat (40) @(negedge clk);
        count(16);
        chk("e_d5_hi0", nh[0][0], 5);
        chk("e_d5_lo0", nl[0][0], 11);
        chk("e_d15_hi1", nh[0][1], 15);
        chk("e_d15_lo1", nl[0][1], 1);
        chk("e_ps_cnt", np[0], 1);
        count(30);
        chk("c_d5_hi0", nh[1][0], 9);
        chk("c_d5_lo0", nl[1][0], 21);
        chk("c_d15_hi1", nh[1][1], 29);
        chk("c_d15_lo1", nl[1][1], 1);

        set(8, 0, 2);
        repeat (40) @(negedge clk);
        count(16);
        chk("e_d8dt2_hi0", nh[0][0], 6);
        chk("e_d8dt2_lo0", nl[0][0], 6);
        chk("e_d0dt2_hi1", nh[0][1], 0);
        chk("e_d0dt2_lo1", nl[0][1], 16);
        count(30);
        chk("c_d8dt2_hi0", nh[1][0], 13);
        chk("c_d8dt2_lo0", nl[1][0], 13);

        set(4, 0, 0);
        repeat (40) @(negedge clk);
        count(30);
        chk("c_d4_hi0", nh[1][0], 7);
        chk("c_d4_lo0", nl[1][0], 23);
        chk("c_ps_cnt", np[1], 1);

        set(5, 15, 10);
        repeat (40) @(negedge clk);
        count(16);
        chk("e_dt10_hi0", nh[0][0], 0);
        chk("e_dt10_lo0", nl[0][0], 1);
        chk("e_dt10_hi1", nh[0][1], 5);
        chk("e_dt10_lo1", nl[0][1], 0);

        set(5, 0, 0);
        repeat (40) @(negedge clk);
        wait_cnt(1);
        fork
            count(16);
            begin
                repeat (6) @(negedge clk);
                duty = {W'(0), W'(3)};
                duty_vld = 1'b1;
                @(negedge clk);
                duty_vld = 1'b0;
            end
        join
        chk("midvld_cur_hi0", nh[0][0], 5);
        count(16);
        chk("midvld_next_hi0", nh[0][0], 3);
        wait_cnt(15);
        duty = {W'(0), W'(6)};
        duty_vld = 1'b1;
        @(negedge clk);
        duty_vld = 1'b0;
        wait_cnt(1);
        count(16);
        chk("lastvld_next_hi0", nh[0][0], 6);

        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        chk("en_off_e", 32'(hi[0] | lo[0]), 0);
        chk("en_off_c", 32'(hi[1] | lo[1]), 0);
        chk("en_off_ps", 32'(ps[0]), 0);
        repeat (3) @(negedge clk);
        en = 1'b1;
        #1;
        chk("en_on_ps", 32'(ps[0]), 1);

        repeat (20) @(negedge clk);
        #2;
        chk("active_pre_rst", 32'(hi[0] | lo[0]), 3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_e", 32'({hi[0], lo[0]}), 0);
        chk("async_rst_c", 32'({hi[1], lo[1]}), 0);
        chk("async_rst_ps", 32'({ps[0], ps[1]}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
